// File: rtl/apb_regbank.sv
`default_nettype none
// ============================================================================
// Module   : apb_regbank
// Brief    : Parametrised APB3 slave register bank. Registers are word
//            aligned, each has its own reset value and may be read-only
//            (reads hardware status). Supports PREADY wait states, PSLVERR
//            and one-cycle per-register write pulses.
// Options  : APB_REGBANK_PSTRB_EN - honour PSTRB byte strobes on writes.
// Revision : 1.0 - initial release
// ============================================================================
module apb_regbank #(
   parameter int                            DATA_WIDTH  = 32,
   parameter int                            ADDR_WIDTH  = 12,
   parameter int                            NUM_REGS    = 8,
   parameter int                            WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]           RO_MASK     = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           i_pclk,
   input  logic                           i_presetn,
   input  logic [ADDR_WIDTH-1:0]          i_paddr,
   input  logic                           i_psel,
   input  logic                           i_penable,
   input  logic                           i_pwrite,
   input  logic [DATA_WIDTH-1:0]          i_pwdata,
   input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
   output logic [DATA_WIDTH-1:0]          o_prdata,
   output logic                           o_pready,
   output logic                           o_pslverr,
   output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_q,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] i_hw_status,
   output logic [NUM_REGS-1:0]            o_wr_pulse
);

   localparam int         c_NBYTES = DATA_WIDTH / 8;
   localparam int         c_IDXW   = ADDR_WIDTH - 2;
   localparam logic [3:0] c_WS     = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t                         r_state;
   logic [3:0]                     r_cnt;
   logic [NUM_REGS*DATA_WIDTH-1:0] r_regs;
   logic [NUM_REGS-1:0]            r_wr_pulse;

   logic [c_IDXW-1:0]              w_idx;
   logic [NUM_REGS-1:0]            w_hit;
   logic                           w_ro;
   logic                           w_err;
   logic                           w_done;
   logic                           w_commit;
   logic [c_NBYTES-1:0]            w_strb;
   logic [DATA_WIDTH-1:0]          w_rdata;

   assign w_idx = i_paddr[ADDR_WIDTH-1:2];

`ifdef APB_REGBANK_PSTRB_EN
   assign w_strb = i_pstrb;
`else
   // Strobes are forced to all-ones; OR-ing keeps the port referenced.
   assign w_strb = i_pstrb | {c_NBYTES{1'b1}};
`endif

   // Address decode: one-hot register hit, read-only flag and error.
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_hit[i] = (int'(w_idx) == i);
      end
      w_ro  = |(w_hit & RO_MASK);
      w_err = (i_paddr[1:0] != 2'b00) | ~(|w_hit) | (i_pwrite & w_ro);
   end

   // Read source mux: status input for read-only registers, storage otherwise.
   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_hit[i]) begin
            w_rdata = RO_MASK[i] ? i_hw_status[i*DATA_WIDTH +: DATA_WIDTH]
                                 : r_regs[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_done   = (r_state == S_ACCESS) && (r_cnt == c_WS);
   assign w_commit = w_done & ~w_err & i_pwrite & (|w_strb);

   assign o_pready   = w_done;
   assign o_pslverr  = w_done & w_err;
   assign o_prdata   = (w_done & ~w_err & ~i_pwrite) ? w_rdata : '0;
   assign o_reg_q    = r_regs;
   assign o_wr_pulse = r_wr_pulse;

   // Transfer sequencing and wait-state counting.
   always_ff @(posedge i_pclk or negedge i_presetn) begin
      if (!i_presetn) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_psel && !i_penable) r_state <= S_SETUP;
            end
            S_SETUP: begin
               r_cnt   <= 4'd0;
               r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (w_done) begin
                  r_state <= (i_psel && !i_penable) ? S_SETUP : S_IDLE;
               end else if (!i_psel) begin
                  r_state <= S_IDLE;
               end else if (r_cnt < c_WS) begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Register storage with byte-granular commit and a pulse the cycle after.
   always_ff @(posedge i_pclk or negedge i_presetn) begin
      if (!i_presetn) begin
         r_regs     <= RESET_VAL;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (w_hit[i]) begin
                  r_wr_pulse[i] <= 1'b1;
                  for (int b = 0; b < c_NBYTES; b++) begin
                     if (w_strb[b]) begin
                        r_regs[i*DATA_WIDTH + b*8 +: 8] <= i_pwdata[b*8 +: 8];
                     end
                  end
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_regbank
// Brief    : Self-checking bench for apb_regbank. Three banks with 0, 2 and 3
//            wait states share the APB bus; each has its own PSEL.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_regbank;

   localparam logic [7:0]   RO = 8'h08;
   localparam logic [255:0] RV = {32'h7070_0707, 32'h6060_0606, 32'h5050_0505,
                                  32'h4040_0404, 32'h3030_0303, 32'h2020_0202,
                                  32'hface_5678, 32'hcafe_1234};

   logic          clk = 1'b0;
   logic          presetn;
   logic [11:0]   paddr;
   logic [2:0]    psel_v;
   logic          penable;
   logic          pwrite;
   logic [31:0]   pwdata;
   logic [3:0]    pstrb;
   logic [255:0]  hw;

   wire  [31:0]   prdata_a [3];
   wire  [2:0]    pready_v;
   wire  [2:0]    pslverr_v;
   wire  [255:0]  regq_a [3];
   wire  [7:0]    pulse_a [3];

   int            total = 0;
   int            bad   = 0;
   logic [31:0]   mdl [3][8];

   always #5 clk = ~clk;

   apb_regbank #(.WAIT_STATES(0), .RO_MASK(RO), .RESET_VAL(RV)) u_ws0 (
      .i_pclk(clk), .i_presetn(presetn), .i_paddr(paddr), .i_psel(psel_v[0]),
      .i_penable(penable), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
      .o_prdata(prdata_a[0]), .o_pready(pready_v[0]), .o_pslverr(pslverr_v[0]),
      .o_reg_q(regq_a[0]), .i_hw_status(hw), .o_wr_pulse(pulse_a[0]));

   apb_regbank #(.WAIT_STATES(2), .RO_MASK(RO), .RESET_VAL(RV)) u_ws2 (
      .i_pclk(clk), .i_presetn(presetn), .i_paddr(paddr), .i_psel(psel_v[1]),
      .i_penable(penable), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
      .o_prdata(prdata_a[1]), .o_pready(pready_v[1]), .o_pslverr(pslverr_v[1]),
      .o_reg_q(regq_a[1]), .i_hw_status(hw), .o_wr_pulse(pulse_a[1]));

   apb_regbank #(.WAIT_STATES(3), .RO_MASK(RO), .RESET_VAL(RV)) u_ws3 (
      .i_pclk(clk), .i_presetn(presetn), .i_paddr(paddr), .i_psel(psel_v[2]),
      .i_penable(penable), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
      .o_prdata(prdata_a[2]), .o_pready(pready_v[2]), .o_pslverr(pslverr_v[2]),
      .o_reg_q(regq_a[2]), .i_hw_status(hw), .o_wr_pulse(pulse_a[2]));

   function automatic int ws_of(input int t);
      return (t == 0) ? 0 : (t == 1) ? 2 : 3;
   endfunction

   function automatic logic [255:0] flat(input int t);
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = mdl[t][i];
      return v;
   endfunction

   function automatic logic [3:0] eff_strb(input logic [3:0] s);
`ifdef APB_REGBANK_PSTRB_EN
      return s;
`else
      return (s == s) ? 4'hF : 4'hF;
`endif
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [11:0] rand_addr();
      int k;
      k = $urandom_range(0, 7);
      if (k == 0) return {7'($urandom_range(0, 7)), 3'd0, 2'($urandom_range(1, 3))};
      if (k == 1) return {10'($urandom_range(8, 1023)), 2'b00};
      return {7'd0, 3'($urandom_range(0, 7)), 2'b00};
   endfunction

   task automatic model_reset();
      for (int t = 0; t < 3; t++)
         for (int i = 0; i < 8; i++) mdl[t][i] = RV[i*32 +: 32];
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full APB transfer on bank t, checked against the model.
   task automatic xfer(input int t, input logic [11:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s);
      int          waits;
      logic        got;
      logic [2:0]  i3;
      logic        exp_err;
      logic [31:0] exp_rd;
      logic [7:0]  exp_pulse;
      i3      = a[4:2];
      exp_err = (a[1:0] != 2'b00) || (a[11:2] >= 10'd8) || (w && RO[i3]);
      if (exp_err || w)  exp_rd = 32'h0;
      else if (RO[i3])   exp_rd = hw[int'(i3)*32 +: 32];
      else               exp_rd = mdl[t][i3];
      exp_pulse = (!exp_err && w && eff_strb(s) != 4'h0) ? (8'h01 << i3) : 8'h00;

      @(posedge clk); #1;
      chk("pulse_idle0", pulse_a[0], 0);
      chk("pulse_idle1", pulse_a[1], 0);
      chk("pulse_idle2", pulse_a[2], 0);
      psel_v = 3'b001 << t; penable = 1'b0;
      paddr = a; pwrite = w; pwdata = d; pstrb = s;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0; got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (pready_v[t]) begin got = 1'b1; break; end
         @(posedge clk); #1;
         waits++;
      end
      chk("pready_timeout", got, 1);
      if (got) begin
         // The bank spends one SETUP cycle then WAIT_STATES ACCESS cycles low.
         chk("wait_cycles", waits, ws_of(t) + 1);
         chk("pslverr", pslverr_v[t], exp_err);
         chk("prdata", prdata_a[t], exp_rd);
      end
      @(posedge clk); #1;
      psel_v = 3'b000; penable = 1'b0;
      if (got && exp_pulse != 8'h00) mdl[t][i3] = merge(mdl[t][i3], d, eff_strb(s));
      chk("wr_pulse", pulse_a[t], got ? exp_pulse : 8'h00);
      chk("reg_q", regq_a[t], flat(t));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      presetn = 1'b1; psel_v = 3'b000; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      for (int i = 0; i < 8; i++) hw[i*32 +: 32] = 32'hbad0_0000 | i;
      hw[3*32 +: 32] = 32'h0000_0002;
      model_reset();

      // Reset values and idle outputs.
      #3 presetn = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      for (int t = 0; t < 3; t++) begin
         chk("rst_reg_q", regq_a[t], RV);
         chk("rst_pulse", pulse_a[t], 0);
         chk("rst_prdata", prdata_a[t], 0);
      end
      chk("rst_pready", pready_v, 0);
      chk("rst_pslverr", pslverr_v, 0);
      chk("rst_slice0", regq_a[0][31:0], 32'hcafe_1234);
      chk("rst_slice1", regq_a[0][63:32], 32'hface_5678);
      presetn = 1'b1;

      // Zero wait states: write then read back.
      xfer(0, 12'h008, 1'b1, 32'hdead_beef, 4'hF);
      xfer(0, 12'h008, 1'b0, 32'h0, 4'hF);
      chk("raw_value", regq_a[0][95:64], 32'hdead_beef);

      // Two wait states: read reset value.
      xfer(1, 12'h000, 1'b0, 32'h0, 4'hF);

      // Error and read-only accesses.
      xfer(0, 12'h020, 1'b0, 32'h0, 4'hF);
      xfer(0, 12'h020, 1'b1, 32'h1234_5678, 4'hF);
      xfer(0, 12'h006, 1'b0, 32'h0, 4'hF);
      xfer(0, 12'h006, 1'b1, 32'h1111_2222, 4'hF);
      xfer(0, 12'h00C, 1'b1, 32'hffff_ffff, 4'hF);
      xfer(0, 12'h00C, 1'b0, 32'h0, 4'hF);
      xfer(1, 12'h00C, 1'b0, 32'h0, 4'hF);

      // Randomized traffic across all banks.
      for (int n = 0; n < 60; n++) begin
         xfer($urandom_range(0, 2), rand_addr(), 1'($urandom_range(0, 1)),
              $urandom, 4'($urandom_range(0, 15)));
      end

`ifdef APB_REGBANK_PSTRB_EN
      xfer(0, 12'h000, 1'b1, 32'h1122_3344, 4'hF);
      xfer(0, 12'h000, 1'b1, 32'hAABB_CCDD, 4'b0101);
      chk("strb_merge", regq_a[0][31:0], 32'h11BB_33DD);
      xfer(0, 12'h000, 1'b1, 32'h0000_0000, 4'b0000);
      chk("strb_zero", regq_a[0][31:0], 32'h11BB_33DD);
`else
      xfer(0, 12'h000, 1'b1, 32'h5A5A_A5A5, 4'b0000);
      chk("strb_ignored", regq_a[0][31:0], 32'h5A5A_A5A5);
`endif

      // Abort in the second ACCESS cycle of a three-wait-state write.
      xfer(2, 12'h010, 1'b1, 32'h1357_9bdf, 4'hF);
      @(posedge clk); #1;
      psel_v = 3'b100; penable = 1'b0; paddr = 12'h010; pwrite = 1'b1;
      pwdata = 32'hffff_0000; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      chk("abort_setup", pready_v[2], 0);
      @(posedge clk); #1;
      chk("abort_acc1", pready_v[2], 0);
      @(posedge clk); #1;
      chk("abort_acc2", pready_v[2], 0);
      psel_v = 3'b000; penable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("abort_pready", pready_v[2], 0);
         chk("abort_pulse", pulse_a[2], 0);
      end
      chk("abort_reg_q", regq_a[2], flat(2));
      xfer(2, 12'h010, 1'b0, 32'h0, 4'hF);

      // Reset asserted in the middle of an ACCESS phase.
      xfer(2, 12'h000, 1'b1, 32'h0F0F_F0F0, 4'hF);
      @(posedge clk); #1;
      psel_v = 3'b100; penable = 1'b0; paddr = 12'h004; pwrite = 1'b1;
      pwdata = 32'h8888_9999; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #2;
      presetn = 1'b0;
      #1;
      for (int t = 0; t < 3; t++) chk("midrst_reg_q", regq_a[t], RV);
      chk("midrst_pready", pready_v, 0);
      model_reset();
      psel_v = 3'b000; penable = 1'b0;
      @(posedge clk); #1;
      presetn = 1'b1;
      xfer(2, 12'h000, 1'b0, 32'h0, 4'hF);
      xfer(2, 12'h004, 1'b0, 32'h0, 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
